uart_tx_sched: RTL and testbench

//  MMIO bus master for one uart_wc slot (addr 0 status, 1 dvsr, 2 tx data, 3 rx pop).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_sched.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Register map, status bit positions and scheduler state encoding for the
// uart_wc slot master.
package uart_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DVSR   = 2'd1;
  localparam logic [1:0] REG_WDATA  = 2'd2;
  localparam logic [1:0] REG_RXPOP  = 2'd3;

  localparam int TX_FULL_BIT  = 9;
  localparam int RX_EMPTY_BIT = 8;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CFG,
    POLL,
    WRITE
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr,
// wrapping, so the previous grantee has lowest priority.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  always_comb begin
    logic [W-1:0] pos;
    logic         found;
    gnt   = '0;
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = W'((32'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// MMIO master for one uart_wc slot: programs the divisor, then multiplexes
// NUM_REQ packet streams onto the TX data register, polling tx_full per byte.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter logic [10:0] DVSR_INIT = 11'd650
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       cfg_valid,
  input  logic [10:0]                cfg_dvsr,
  output logic                       cfg_ready,
  output logic                       uart_cs,
  output logic                       uart_read,
  output logic                       uart_write,
  output logic [4:0]                 uart_addr,
  output logic [31:0]                uart_wr_data,
  input  logic [31:0]                uart_rd_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(NUM_REQ);

  sched_state_t      state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [10:0]       data_q, data_d;
  logic              last_q, last_d;
  logic [GW-1:0]     arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [7:0]        sel_byte;
  logic              sel_valid;
  logic              sel_last;
  logic              tx_full;
  logic              unused_rd;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign tx_full   = uart_rd_data[TX_FULL_BIT];
  assign unused_rd = ^{uart_rd_data[31:TX_FULL_BIT+1], uart_rd_data[TX_FULL_BIT-1:0]};
  assign grant_id  = grant_q;

  always_comb begin
    sel_byte  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_byte  = req_data[8*i +: 8];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        // Divisor updates win over new packets; data_q doubles as the divisor holder.
        if (cfg_valid) begin
          data_d  = cfg_dvsr;
          state_d = CFG;
        end else if (|arb_gnt) begin
          grant_d = arb_idx;
          state_d = POLL;
        end
      end
      CFG: state_d = IDLE;
      POLL: begin
        if (!tx_full && sel_valid) begin
          data_d  = {3'b0, sel_byte};
          last_d  = sel_last;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (last_q) begin
          ptr_d   = grant_q;
          state_d = IDLE;
        end else begin
          state_d = POLL;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // State sits at INIT throughout reset, so its strobes are masked until release.
  always_comb begin
    uart_cs      = 1'b0;
    uart_read    = 1'b0;
    uart_write   = 1'b0;
    uart_addr    = '0;
    uart_wr_data = '0;
    req_ready    = '0;
    cfg_ready    = 1'b0;
    if (!reset) begin
      case (state_q)
        INIT: begin
          uart_cs      = 1'b1;
          uart_write   = 1'b1;
          uart_addr    = {3'b0, REG_DVSR};
          uart_wr_data = {21'b0, DVSR_INIT};
        end
        CFG: begin
          uart_cs      = 1'b1;
          uart_write   = 1'b1;
          uart_addr    = {3'b0, REG_DVSR};
          uart_wr_data = {21'b0, data_q};
          cfg_ready    = 1'b1;
        end
        POLL: begin
          uart_cs   = 1'b1;
          uart_read = 1'b1;
          uart_addr = {3'b0, REG_STATUS};
        end
        WRITE: begin
          uart_cs            = 1'b1;
          uart_write         = 1'b1;
          uart_addr          = {3'b0, REG_WDATA};
          uart_wr_data       = {24'b0, data_q[7:0]};
          req_ready[grant_q] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = !reset && (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized scoreboard bench for uart_tx_sched: a packet-level round-robin
// model predicts every MMIO write; a monitor checks each bus cycle against it.
module tb_uart_tx_sched;

  localparam int          NR  = 4;
  localparam logic [10:0] DV0 = 11'd650;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*8-1:0]   req_data;
  logic              cfg_valid, cfg_ready;
  logic [10:0]       cfg_dvsr;
  logic              uart_cs, uart_read, uart_write;
  logic [4:0]        uart_addr;
  logic [31:0]       uart_wr_data, uart_rd_data;
  logic [1:0]        grant_id;
  logic              busy;
  logic              tx_full;

  assign uart_rd_data = {22'b0, tx_full, 1'b1, 8'b0};

  uart_tx_sched #(.NUM_REQ(NR), .DVSR_INIT(DV0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .cfg_valid(cfg_valid), .cfg_dvsr(cfg_dvsr), .cfg_ready(cfg_ready),
    .uart_cs(uart_cs), .uart_read(uart_read), .uart_write(uart_write),
    .uart_addr(uart_addr), .uart_wr_data(uart_wr_data), .uart_rd_data(uart_rd_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          req;
    bit          cfg;
  } txn_t;

  function automatic txn_t mk(input logic [1:0] a, input logic [31:0] d, input int r, input bit c);
    txn_t t;
    t.addr = a; t.data = d; t.req = r; t.cfg = c;
    return t;
  endfunction

  txn_t         exp_q[$];
  byte unsigned pk[NR][$];
  bit           pl[NR][$];
  byte unsigned sd[NR][$];
  bit           sl[NR][$];

  int          cyc = 0;
  int          gap_pct = 0, full_pct = 0;
  bit          full_force = 0, cfg_req = 0;
  logic [10:0] cfg_req_val = '0;
  int          gap_cnt[NR];
  int          ready_cnt = 0;
  int          rdy_cyc[$];
  int          ptr_m;
  int          push_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester / config / slot-status driver
  initial begin
    logic [NR-1:0] rdy_s;
    logic          cfr_s;
    bit            in_rst;
    bit            was_last;
    req_valid = '0; req_data = '0; req_last = '0;
    cfg_valid = 1'b0; cfg_dvsr = '0; tx_full = 1'b0;
    for (int i = 0; i < NR; i++) gap_cnt[i] = 0;
    forever begin
      @(negedge clk);
      rdy_s = req_ready;
      cfr_s = cfg_ready;
      @(posedge clk);
      in_rst = reset;
      #1;
      if (in_rst) begin
        req_valid = '0;
        cfg_valid = 1'b0;
        for (int i = 0; i < NR; i++) gap_cnt[i] = 0;
      end else begin
        for (int i = 0; i < NR; i++) begin
          if (rdy_s[i] && req_valid[i]) begin
            was_last = pl[i][0];
            void'(pk[i].pop_front());
            void'(pl[i].pop_front());
            if (!was_last && $urandom_range(99) < gap_pct) gap_cnt[i] = $urandom_range(3, 1);
          end else if (gap_cnt[i] > 0) begin
            gap_cnt[i]--;
          end
          req_valid[i] = (pk[i].size() > 0) && (gap_cnt[i] == 0);
          if (pk[i].size() > 0) begin
            req_data[8*i +: 8] = pk[i][0];
            req_last[i]        = pl[i][0];
          end
        end
        if (cfr_s && cfg_valid) cfg_valid = 1'b0;
        if (cfg_req) begin
          cfg_valid = 1'b1;
          cfg_dvsr  = cfg_req_val;
          cfg_req   = 0;
        end
      end
      tx_full = full_force || ($urandom_range(99) < full_pct);
    end
  end

  // Bus monitor / scoreboard
  initial begin
    bit            prev_ok;
    logic [NR-1:0] prev_valid;
    txn_t          t;
    prev_ok = 0;
    prev_valid = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ok = 0;
      end else begin
        if (uart_cs) begin
          chk("rw_exclusive", {31'b0, uart_read && uart_write}, 32'd0);
          chk("no_rxpop", {31'b0, uart_addr == 5'd3}, 32'd0);
        end
        if (uart_cs && uart_write) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=addr%0d/0x%0h required=none", uart_addr, uart_wr_data);
          end else begin
            t = exp_q.pop_front();
            chk("wr_addr", {27'b0, uart_addr}, {30'b0, t.addr});
            chk("wr_data", uart_wr_data, t.data);
            if (t.req >= 0) begin
              chk("req_ready_onehot", {28'b0, req_ready}, 32'(1 << t.req));
              chk("poll_before_write", {31'b0, prev_ok && prev_valid[t.req]}, 32'd1);
            end else begin
              chk("req_ready_on_cfg", {28'b0, req_ready}, 32'd0);
            end
            chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, t.cfg});
          end
        end else begin
          chk("ready_quiet", {27'b0, req_ready, cfg_ready}, 32'd0);
        end
        if (req_ready != '0) begin
          ready_cnt++;
          rdy_cyc.push_back(cyc);
        end
        prev_ok    = uart_cs && uart_read && !uart_write && (uart_addr == 5'd0) && !uart_rd_data[9];
        prev_valid = req_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic add_pkt(input int r, input int len, input bit rnd, input byte unsigned base);
    for (int k = 0; k < len; k++) begin
      sd[r].push_back(rnd ? 8'($urandom_range(255)) : 8'(base + k));
      sl[r].push_back(k == len - 1);
    end
  endtask

  function automatic bit pending();
    bit p = cfg_req || cfg_valid;
    for (int i = 0; i < NR; i++) if (pk[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic outputs_zero(input string tag);
    chk({tag, "_strobes"}, {27'b0, uart_cs, uart_read, uart_write, cfg_ready, busy}, 32'd0);
    chk({tag, "_addr"}, {27'b0, uart_addr}, 32'd0);
    chk({tag, "_wdata"}, uart_wr_data, 32'd0);
    chk({tag, "_ready"}, {28'b0, req_ready}, 32'd0);
    chk({tag, "_grant"}, {30'b0, grant_id}, 32'd0);
  endtask

  task automatic wait_ready(input int base);
    int w = 0;
    while (ready_cnt == base && w < 500) begin
      @(negedge clk); #1;
      w++;
    end
    if (w >= 500) begin
      checks++;
      failures++;
      $display("FAIL ready_wait actual=none required=req_ready");
    end
  endtask

  // mode: 0 plain, 1 cfg arrives after first byte, 2 20-cycle tx_full burst after first byte
  task automatic run_round(input bit cfg_start, input int mode, input logic [10:0] cv,
                           input int gp, input int fp);
    byte unsigned md[NR][$];
    bit           ml[NR][$];
    bit           more, first, l;
    byte unsigned b;
    int           j, c, w, rc0, rd, wr;
    for (int i = 0; i < NR; i++) begin md[i] = sd[i]; ml[i] = sl[i]; end
    if (cfg_start) exp_q.push_back(mk(2'd1, {21'b0, cv}, -1, 1));
    first = 1;
    more  = 1;
    while (more) begin
      more = 0;
      j = 0;
      for (int k = 1; k <= NR; k++) begin
        c = (ptr_m + k) % NR;
        if (!more && md[c].size() > 0) begin more = 1; j = c; end
      end
      if (more) begin
        l = 0;
        while (!l) begin
          b = md[j].pop_front();
          l = ml[j].pop_front();
          exp_q.push_back(mk(2'd2, {24'b0, b}, j, 0));
        end
        ptr_m = j;
        if (first && mode == 1) exp_q.push_back(mk(2'd1, {21'b0, cv}, -1, 1));
        first = 0;
      end
    end
    @(negedge clk); #1;
    gap_pct  = gp;
    full_pct = fp;
    for (int i = 0; i < NR; i++) begin
      while (sd[i].size() > 0) begin
        pk[i].push_back(sd[i].pop_front());
        pl[i].push_back(sl[i].pop_front());
      end
    end
    if (cfg_start) begin cfg_req_val = cv; cfg_req = 1; end
    push_cyc = cyc;
    rdy_cyc.delete();
    rc0 = ready_cnt;
    if (mode == 1) begin
      wait_ready(rc0);
      cfg_req_val = cv;
      cfg_req = 1;
    end else if (mode == 2) begin
      wait_ready(rc0);
      full_force = 1;
      @(posedge clk); #2;
      rd = 0; wr = 0;
      repeat (20) begin
        @(negedge clk);
        if (uart_cs && uart_read && uart_addr == 5'd0) rd++;
        if (uart_write) wr++;
      end
      full_force = 0;
      chk("stall_reads", 32'(rd), 32'd20);
      chk("stall_writes", 32'(wr), 32'd0);
    end
    w = 0;
    while ((exp_q.size() > 0 || pending()) && w < 5000) begin
      @(negedge clk); #1;
      w++;
    end
    if (w >= 5000) begin
      checks++;
      failures++;
      $display("FAIL round_timeout actual=%0d_pending required=0", exp_q.size());
    end
    gap_pct = 0;
    full_pct = 0;
    repeat (3) @(negedge clk);
    chk("idle_after_round", {31'b0, busy}, 32'd0);
    chk("grant_id", {30'b0, grant_id}, 32'(ptr_m));
  endtask

  initial begin
    int rc0, w, np;
    bit cs;
    reset = 1'b1;
    ptr_m = NR - 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outputs_zero("reset");

    // Release just after an edge so the INIT cycle is observable at the next negedge.
    exp_q.push_back(mk(2'd1, {21'b0, DV0}, -1, 0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("init_busy", {31'b0, busy}, 32'd1);
    @(negedge clk); #1;
    chk("init_write_seen", 32'(exp_q.size()), 32'd0);
    chk("idle_after_init", {31'b0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // Two packets each on req0 and req2: expect 0,2,0,2 by packet.
    add_pkt(0, 2, 1, 0); add_pkt(0, 2, 1, 0);
    add_pkt(2, 2, 1, 0); add_pkt(2, 2, 1, 0);
    run_round(0, 0, '0, 0, 0);

    // req0 sends 0x41..0x43: latency and 2-cycle spacing.
    add_pkt(0, 3, 0, 8'h41);
    run_round(0, 0, '0, 0, 0);
    chk("ready_pulses", 32'(rdy_cyc.size()), 32'd3);
    if (rdy_cyc.size() == 3) begin
      chk("first_latency", 32'(rdy_cyc[0] - (push_cyc + 1)), 32'd2);
      chk("spacing_1", 32'(rdy_cyc[1] - rdy_cyc[0]), 32'd2);
      chk("spacing_2", 32'(rdy_cyc[2] - rdy_cyc[1]), 32'd2);
    end

    // tx_full held for 20 cycles mid-packet.
    add_pkt(1, 5, 1, 0);
    run_round(0, 2, '0, 0, 0);

    // Divisor change requested during req1's packet.
    add_pkt(1, 3, 1, 0); add_pkt(1, 2, 1, 0);
    run_round(0, 1, 11'd325, 0, 0);

    // Randomized rounds with stalls, gaps and occasional divisor writes.
    repeat (12) begin
      for (int r = 0; r < NR; r++) begin
        if ($urandom_range(1) == 1) begin
          np = $urandom_range(2, 1);
          repeat (np) add_pkt(r, $urandom_range(4, 1), 1, 0);
        end
      end
      cs = ($urandom_range(3) == 0);
      run_round(cs, 0, 11'($urandom_range(2047, 1)), 20, 25);
    end

    // Reset during the write of byte 2 of 4.
    for (int k = 0; k < 4; k++) begin
      pk[3].push_back(8'h60 + 8'(k));
      pl[3].push_back(k == 3);
      exp_q.push_back(mk(2'd2, {24'b0, 8'h60 + 8'(k)}, 3, 0));
    end
    rc0 = ready_cnt;
    w = 0;
    while (ready_cnt < rc0 + 2 && w < 500) begin
      @(negedge clk); #1;
      w++;
    end
    chk("second_byte_reached", {31'b0, ready_cnt >= rc0 + 2}, 32'd1);
    reset = 1'b1;
    #1;
    outputs_zero("reset_async");
    @(posedge clk); #2;
    chk("abort_no_ack", 32'(pk[3].size()), 32'd3);
    for (int i = 0; i < NR; i++) begin pk[i].delete(); pl[i].delete(); end
    exp_q.delete();
    ptr_m = NR - 1;
    exp_q.push_back(mk(2'd1, {21'b0, DV0}, -1, 0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("reinit_write_seen", 32'(exp_q.size()), 32'd0);

    // Pointer restarts after reset: req0 ahead of req3.
    add_pkt(3, 2, 1, 0); add_pkt(0, 2, 1, 0);
    run_round(0, 0, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
